// File: rtl/node_reg_ready.sv
// Valid/ready pipeline node with both directions registered.
// A two-entry skid buffer (output register + skid register) lets the
// upstream ready be a flop while still sustaining one word per cycle.
//
// state | meaning
// EMPTY | no word held; valid_down_out=0
// BUSY  | one word in the output register
// FULL  | output register and skid register both hold a word; ready_up_out=0
module node_reg_ready #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_up_in,
    input  logic             ready_down_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    output logic             ready_up_out
);

    // State is encoded directly by {valid_down_out, skid_valid}.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             valid_q, valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic             up_fire;
    logic             down_fire;
    logic [1:0]       state;

    assign up_fire   = valid_up_in & ready_q;
    assign down_fire = valid_q & ready_down_in;
    assign state     = {valid_q, skid_valid_q};

    // Next-state logic for the output/skid registers and the registered ready.
    always_comb begin
        data_d       = data_q;
        skid_data_d  = skid_data_q;
        valid_d      = valid_q;
        skid_valid_d = skid_valid_q;
        case (state)
            ST_EMPTY: begin
                if (up_fire) begin
                    valid_d = 1'b1;
                    data_d  = data_in;
                end
            end
            ST_BUSY: begin
                if (up_fire && down_fire) begin
                    data_d = data_in;
                end else if (up_fire) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = data_in;
                end else if (down_fire) begin
                    valid_d = 1'b0;
                end
            end
            ST_FULL: begin
                // up_fire cannot happen here: ready_q is low while FULL.
                if (down_fire) begin
                    data_d       = skid_data_q;
                    skid_valid_d = 1'b0;
                end
            end
            default: begin
                // Unreachable (0,1) encoding: recover to EMPTY.
                skid_valid_d = 1'b0;
                valid_d      = 1'b0;
            end
        endcase
        // Ready is low exactly in the cycles the node will be FULL.
        ready_d = ~(valid_d & skid_valid_d);
    end

    // State registers with asynchronous clear; all buffered words are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q       <= '0;
            skid_data_q  <= '0;
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            data_q       <= data_d;
            skid_data_q  <= skid_data_d;
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign data_out       = data_q;
    assign valid_down_out = valid_q;
    assign ready_up_out   = ready_q;

endmodule

// File: tb/tb_node_reg_ready.sv
// Directed, table-driven bench for node_reg_ready.
module tb_node_reg_ready;

    typedef struct {
        logic        vu;
        logic        rd;
        logic [31:0] din;
        logic        ev;
        logic        er;
        logic [31:0] ed;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        valid_up_in;
    logic        ready_down_in;
    logic [31:0] data_out;
    logic        valid_down_out;
    logic        ready_up_out;

    int n_pass;
    int n_total;
    vec_t vecs[$];

    node_reg_ready #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .valid_up_in    (valid_up_in),
        .ready_down_in  (ready_down_in),
        .data_out       (data_out),
        .valid_down_out (valid_down_out),
        .ready_up_out   (ready_up_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_out(input string name, input logic ev, input logic er, input logic [31:0] ed);
        chk({name, ".valid"}, {31'd0, valid_down_out}, {31'd0, ev});
        chk({name, ".ready"}, {31'd0, ready_up_out}, {31'd0, er});
        chk({name, ".data"}, data_out, ed);
    endtask

    task automatic add(input logic vu, input logic rd, input logic [31:0] din,
                       input logic ev, input logic er, input logic [31:0] ed, input string name);
        vec_t v;
        v.vu = vu; v.rd = rd; v.din = din; v.ev = ev; v.er = er; v.ed = ed; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, then check outputs 1 time unit after the edge.
    task automatic step(input logic vu, input logic rd, input logic [31:0] din,
                        input logic ev, input logic er, input logic [31:0] ed, input string name);
        valid_up_in   = vu;
        ready_down_in = rd;
        data_in       = din;
        @(posedge clk);
        #1;
        chk_out(name, ev, er, ed);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;

        // Single word
        add(1, 1, 32'hA5A5_0001, 1, 1, 32'hA5A5_0001, "single_in");
        add(0, 1, 32'h0,         0, 1, 32'hA5A5_0001, "single_out");
        add(0, 1, 32'h0,         0, 1, 32'hA5A5_0001, "single_idle");
        // Streaming 0x1..0x10
        for (int i = 1; i <= 16; i++)
            add(1, 1, 32'(i), 1, 1, 32'(i), $sformatf("stream_%0d", i));
        add(0, 1, 32'h0, 0, 1, 32'h10, "stream_end");
        // Backpressure: ready_down_in low for 4 cycles
        add(1, 1, 32'h20, 1, 1, 32'h20, "bp_20");
        add(1, 1, 32'h21, 1, 1, 32'h21, "bp_21");
        add(1, 0, 32'h22, 1, 0, 32'h21, "bp_full");
        add(1, 0, 32'h23, 1, 0, 32'h21, "bp_hold1");
        add(1, 0, 32'h23, 1, 0, 32'h21, "bp_hold2");
        add(1, 0, 32'h23, 1, 0, 32'h21, "bp_hold3");
        add(1, 1, 32'h23, 1, 1, 32'h22, "bp_drain22");
        add(1, 1, 32'h23, 1, 1, 32'h23, "bp_23");
        add(1, 1, 32'h24, 1, 1, 32'h24, "bp_24");
        add(0, 1, 32'h0,  0, 1, 32'h24, "bp_end");
        // Simultaneous fire in BUSY
        add(1, 1, 32'h30, 1, 1, 32'h30, "sim_30");
        for (int i = 1; i <= 8; i++)
            add(1, 1, 32'h30 + 32'(i), 1, 1, 32'h30 + 32'(i), $sformatf("sim_%0d", i));
        add(0, 1, 32'h0, 0, 1, 32'h38, "sim_end");
        // BUSY hold with no handshake on either side
        add(1, 0, 32'h40, 1, 1, 32'h40, "busy_load");
        add(0, 0, 32'h41, 1, 1, 32'h40, "busy_hold");
        add(0, 1, 32'h41, 0, 1, 32'h40, "busy_drain");

        // Reset / idle
        rst_n = 1'b0;
        valid_up_in = 1'b0;
        ready_down_in = 1'b0;
        data_in = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("rst_%0d", i), 0, 0, 32'h0);
        end
        rst_n = 1'b1;
        step(0, 0, 32'h0, 0, 1, 32'h0, "rst_release");

        foreach (vecs[k])
            step(vecs[k].vu, vecs[k].rd, vecs[k].din, vecs[k].ev, vecs[k].er, vecs[k].ed, vecs[k].name);

        // Reset while FULL: held words must vanish
        step(1, 0, 32'h50, 1, 1, 32'h50, "mr_load");
        step(1, 0, 32'h51, 1, 0, 32'h50, "mr_full");
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("mr_async", 0, 0, 32'h0);
        valid_up_in = 1'b0;
        ready_down_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out("mr_held", 0, 0, 32'h0);
        rst_n = 1'b1;
        step(0, 1, 32'h0,    0, 1, 32'h0,    "mr_release");
        step(0, 1, 32'h0,    0, 1, 32'h0,    "mr_no_ghost");
        step(1, 1, 32'hBEEF, 1, 1, 32'hBEEF, "mr_beef");
        step(0, 1, 32'h0,    0, 1, 32'hBEEF, "mr_beef_out");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
